alu_bist: RTL and testbench

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_bist.sv | 166 ++++++++++++++++
 tb/tb_alu_bist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist -- built-in self-test initiator for a 32-bit ALU.
//
// Drives a fixed 11-entry vector table onto the ALU operand/op outputs, waits
// SETTLE_CYCLES cycles for the ALU to settle, then compares the ALU result
// against the table's expected value. Reports a mismatch count and the index
// of the first failing vector.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   start      one-cycle pulse; begins a run (ignored while busy)
//   A_out      operand A to the ALU
//   B_out      operand B to the ALU
//   ALUOp_out  operation select to the ALU
//   ALURes_in  ALU result (combinational from A_out/B_out/ALUOp_out)
//   busy       high while a run is in progress
//   done       high once a run completes, held until next start or reset
//   pass       done and no mismatches
//   err_count  mismatching vectors in the current/last run (saturates at 15)
//   fail_idx   index of the first mismatching vector, 4'hF if none
// ---------------------------------------------------------------------------
module alu_bist #(
    parameter int unsigned SETTLE_CYCLES = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] A_out,
    output logic [31:0] B_out,
    output logic [3:0]  ALUOp_out,
    input  logic [31:0] ALURes_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_count,
    output logic [3:0]  fail_idx
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LD = SETTLE_CYCLES[3:0];
    localparam logic [3:0] LAST_IDX  = 4'd10;
    localparam logic [3:0] NO_FAIL   = 4'hF;

    state_t      state_r;
    logic [3:0]  idx_r;
    logic [3:0]  cnt_r;

    logic [99:0] vec_s;
    logic [31:0] exp_s;
    logic        mismatch_s;
    logic [3:0]  err_next_s;
    logic [3:0]  fail_next_s;

    // Vector table entry packed as {op[3:0], a[31:0], b[31:0], expected[31:0]}.
    function automatic logic [99:0] vec_f(input logic [3:0] i);
        case (i)
            4'd0:    vec_f = {4'b0000, 32'h0000000A, 32'h00000005, 32'h0000000F};
            4'd1:    vec_f = {4'b1000, 32'h0000000A, 32'h00000014, 32'hFFFFFFF6};
            4'd2:    vec_f = {4'b0001, 32'h00000003, 32'h00000002, 32'h0000000C};
            4'd3:    vec_f = {4'b0010, 32'hFFFFFFFB, 32'h00000003, 32'h00000001};
            4'd4:    vec_f = {4'b0011, 32'hFFFFFFFB, 32'h00000003, 32'h00000000};
            4'd5:    vec_f = {4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF};
            4'd6:    vec_f = {4'b0101, 32'hFFFFFFC0, 32'h00000003, 32'h1FFFFFF8};
            4'd7:    vec_f = {4'b1101, 32'hFFFFFFC0, 32'h00000003, 32'hFFFFFFF8};
            4'd8:    vec_f = {4'b0110, 32'hAAAA0000, 32'h0000BBBB, 32'hAAAABBBB};
            4'd9:    vec_f = {4'b0111, 32'hFFFF0000, 32'h00FF00FF, 32'h00FF0000};
            4'd10:   vec_f = {4'b1001, 32'h12345678, 32'h87654321, 32'h87654321};
            default: vec_f = {4'b0000, 32'h00000000, 32'h00000000, 32'h00000000};
        endcase
    endfunction

    // Current vector lookup and next-value computation for the result counters.
    always_comb begin
        vec_s      = vec_f(idx_r);
        exp_s      = vec_s[31:0];
        mismatch_s = (ALURes_in != exp_s);
        if (mismatch_s && (err_count != 4'hF)) begin
            err_next_s = err_count + 4'd1;
        end else begin
            err_next_s = err_count;
        end
        // Only the first failing vector is recorded.
        if (mismatch_s && (fail_idx == NO_FAIL)) begin
            fail_next_s = idx_r;
        end else begin
            fail_next_s = fail_idx;
        end
    end

    // Sequencer FSM with registered ALU drive and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            cnt_r     <= 4'd0;
            A_out     <= 32'd0;
            B_out     <= 32'd0;
            ALUOp_out <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_idx  <= NO_FAIL;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_r     <= 4'd0;
                        err_count <= 4'd0;
                        fail_idx  <= NO_FAIL;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= ST_DRIVE;
                    end else begin
                        state_r   <= state_r;
                    end
                end
                ST_DRIVE: begin
                    ALUOp_out <= vec_s[99:96];
                    A_out     <= vec_s[95:64];
                    B_out     <= vec_s[63:32];
                    cnt_r     <= SETTLE_LD;
                    state_r   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Counter was loaded with SETTLE_CYCLES, so leaving at 1
                    // spends exactly SETTLE_CYCLES cycles here.
                    if (cnt_r <= 4'd1) begin
                        state_r <= ST_CHECK;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next_s;
                    fail_idx  <= fail_next_s;
                    if (idx_r == LAST_IDX) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next_s == 4'd0);
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + 4'd1;
                        state_r <= ST_DRIVE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// ---------------------------------------------------------------------------
// tb_alu_bist -- self-checking bench for alu_bist.
// Two instances (SETTLE_CYCLES = 1 and 3) share one behavioural ALU model
// whose fault mode is selectable; expected BIST results come from comparing
// the faulty model against the fault-free model over the vector operands.
// ---------------------------------------------------------------------------
module tb_alu_bist;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        start1_s, start3_s;
    logic [31:0] a1_s, b1_s, res1_s, a3_s, b3_s, res3_s;
    logic [3:0]  op1_s, op3_s, err1_s, err3_s, fi1_s, fi3_s;
    logic        busy1_s, done1_s, pass1_s, busy3_s, done3_s, pass3_s;

    // ALU fault mode: 0 correct, 1 SRA acts as SRL, 2 always zero, 3 opmask flips bit 0
    int          mode_s;
    logic [15:0] opmask_s;
    int          n_total_s;
    int          n_pass_s;

    logic [3:0]  tv_op_s [11];
    logic [31:0] tv_a_s  [11];
    logic [31:0] tv_b_s  [11];

    // Free-running 100 MHz clock.
    always #5 clk_s = ~clk_s;

    alu_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk_s), .rst(rst_s), .start(start1_s),
        .A_out(a1_s), .B_out(b1_s), .ALUOp_out(op1_s), .ALURes_in(res1_s),
        .busy(busy1_s), .done(done1_s), .pass(pass1_s),
        .err_count(err1_s), .fail_idx(fi1_s)
    );

    alu_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk_s), .rst(rst_s), .start(start3_s),
        .A_out(a3_s), .B_out(b3_s), .ALUOp_out(op3_s), .ALURes_in(res3_s),
        .busy(busy3_s), .done(done3_s), .pass(pass3_s),
        .err_count(err3_s), .fail_idx(fi3_s)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input int md,
                                              input logic [15:0] msk);
        logic [31:0] r;
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: begin
                if (md == 1) r = a >> b[4:0];
                else         r = $signed(a) >>> b[4:0];
            end
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1001: r = b;
            default: r = 32'd0;
        endcase
        if (md == 2) r = 32'd0;
        if (md == 3 && msk[op]) r = r ^ 32'd1;
        return r;
    endfunction

    assign res1_s = alu_model(op1_s, a1_s, b1_s, mode_s, opmask_s);
    assign res3_s = alu_model(op3_s, a3_s, b3_s, mode_s, opmask_s);

    // Observed output selector: which 0 A,1 B,2 op,3 busy,4 done,5 pass,6 err,7 fail_idx
    function automatic logic [31:0] obs(input int sel, input int which);
        case (which)
            0: return sel ? a3_s : a1_s;
            1: return sel ? b3_s : b1_s;
            2: return {28'd0, sel ? op3_s : op1_s};
            3: return {31'd0, sel ? busy3_s : busy1_s};
            4: return {31'd0, sel ? done3_s : done1_s};
            5: return {31'd0, sel ? pass3_s : pass1_s};
            6: return {28'd0, sel ? err3_s : err1_s};
            7: return {28'd0, sel ? fi3_s : fi1_s};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total_s++;
        assert (o === e) n_pass_s++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start3_s = v;
        else          start1_s = v;
    endtask

    // Expected error count / first failing index from model disagreement.
    task automatic expect_from_model(output int e, output int f);
        e = 0;
        f = 15;
        for (int v = 0; v < 11; v++) begin
            if (alu_model(tv_op_s[v], tv_a_s[v], tv_b_s[v], mode_s, opmask_s) !==
                alu_model(tv_op_s[v], tv_a_s[v], tv_b_s[v], 0, 16'h0000)) begin
                if (e < 15) e++;
                if (f == 15) f = v;
            end
        end
    endtask

    // One full run; poke_edge > 0 re-pulses start after that edge while busy.
    task automatic run(input int sel, input int poke_edge);
        int s, per, target, e, f, busy_n;
        s      = (sel != 0) ? 3 : 1;
        per    = s + 2;
        target = 1 + 11 * per;
        expect_from_model(e, f);
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        chk("start_busy", obs(sel, 3), 32'd1);
        chk("start_done_clr", obs(sel, 4), 32'd0);
        chk("start_err_clr", obs(sel, 6), 32'd0);
        chk("start_fail_clr", obs(sel, 7), 32'd15);
        busy_n = 1;
        for (int k = 2; k <= target; k++) begin
            tick();
            for (int v = 0; v < 11; v++) begin
                if (k == 2 + per * v) begin
                    chk("drive_op", obs(sel, 2), {28'd0, tv_op_s[v]});
                    chk("drive_a", obs(sel, 0), tv_a_s[v]);
                    chk("drive_b", obs(sel, 1), tv_b_s[v]);
                end
                if (k == 1 + per * (v + 1)) chk("hold_op", obs(sel, 2), {28'd0, tv_op_s[v]});
            end
            if (k < target && obs(sel, 3) == 32'd1) busy_n++;
            if (k == target - 1) chk("done_early", obs(sel, 4), 32'd0);
            set_start(sel, (k == poke_edge) ? 1'b1 : 1'b0);
        end
        chk("busy_cycles", busy_n, target - 1);
        chk("done", obs(sel, 4), 32'd1);
        chk("busy_end", obs(sel, 3), 32'd0);
        chk("pass", obs(sel, 5), (e == 0) ? 32'd1 : 32'd0);
        chk("err_count", obs(sel, 6), e);
        chk("fail_idx", obs(sel, 7), f);
    endtask

    task automatic chk_reset_vals(input int sel);
        chk("rst_a", obs(sel, 0), 32'd0);
        chk("rst_b", obs(sel, 1), 32'd0);
        chk("rst_op", obs(sel, 2), 32'd0);
        chk("rst_busy", obs(sel, 3), 32'd0);
        chk("rst_done", obs(sel, 4), 32'd0);
        chk("rst_pass", obs(sel, 5), 32'd0);
        chk("rst_err", obs(sel, 6), 32'd0);
        chk("rst_fail", obs(sel, 7), 32'd15);
    endtask

    initial begin
        logic [10:0] rnd;
        n_total_s = 0;
        n_pass_s  = 0;
        mode_s    = 0;
        opmask_s  = 16'h0000;
        start1_s  = 1'b0;
        start3_s  = 1'b0;
        rst_s     = 1'b1;
        tv_op_s = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                    4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001};
        tv_a_s  = '{32'h0000000A, 32'h0000000A, 32'h00000003, 32'hFFFFFFFB,
                    32'hFFFFFFFB, 32'hF0F0F0F0, 32'hFFFFFFC0, 32'hFFFFFFC0,
                    32'hAAAA0000, 32'hFFFF0000, 32'h12345678};
        tv_b_s  = '{32'h00000005, 32'h00000014, 32'h00000002, 32'h00000003,
                    32'h00000003, 32'h0F0F0F0F, 32'h00000003, 32'h00000003,
                    32'h0000BBBB, 32'h00FF00FF, 32'h87654321};
        #12;
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst_s = 1'b0;
        tick();
        tick();
        chk("idle_no_start", obs(0, 3), 32'd0);

        // Correct ALU, then SRA fault, then stuck-at-zero ALU.
        run(0, 0);
        mode_s = 1;
        run(0, 0);
        mode_s = 2;
        run(0, 0);
        // Restart from DONE with a stray start pulse at vector 3.
        mode_s = 0;
        run(0, 10);

        // Random single-bit result faults on a random subset of vectors.
        mode_s = 3;
        for (int it = 0; it < 4; it++) begin
            rnd = 11'($urandom);
            opmask_s = 16'h0000;
            for (int v = 0; v < 11; v++) begin
                if (rnd[v]) opmask_s[tv_op_s[v]] = 1'b1;
            end
            run(0, 0);
        end
        opmask_s = 16'h0000;
        mode_s   = 0;

        // Asynchronous reset during SETTLE of vector 5.
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        for (int k = 2; k <= 17; k++) tick();
        chk("pre_rst_a", obs(0, 0), 32'hF0F0F0F0);
        #1 rst_s = 1'b1;
        #1;
        chk_reset_vals(0);
        #1 rst_s = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_idle", obs(0, 3), 32'd0);
        chk("post_rst_done", obs(0, 4), 32'd0);
        chk("post_rst_a", obs(0, 0), 32'd0);
        run(0, 0);

        // Longer settle time instance.
        run(1, 0);
        mode_s = 1;
        run(1, 0);
        mode_s = 0;

        $display("%0d/%0d checks passed", n_pass_s, n_total_s);
        $finish;
    end

endmodule
